// File: rtl/bg_lsu_switch_ctrl_if.sv
// Bundle of the config, control and crossbar-switch signals of bg_lsu_switch_ctrl.
// master: the side that loads the table and drives start/step (host or bench).
// slave : the sequencer itself.
interface bg_lsu_switch_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int IW    = 16
);
    localparam int AW = $clog2(DEPTH);

    // configuration port
    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    cfg_data;
    logic          cfg_last;
    // replay control
    logic          start;
    logic [IW-1:0] iter_num;
    logic          step_en;
    // crossbar side and status
    logic [7:0]    switch;
    logic          switch_valid;
    logic [AW-1:0] ctx_idx;
    logic          busy;
    logic          done;
    logic          conflict;
    logic [3:0]    conflict_mask;

    modport master (
        output cfg_valid, cfg_data, cfg_last, start, iter_num, step_en,
        input  cfg_ready, switch, switch_valid, ctx_idx, busy, done,
               conflict, conflict_mask
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, start, iter_num, step_en,
        output cfg_ready, switch, switch_valid, ctx_idx, busy, done,
               conflict, conflict_mask
    );
endinterface

// File: rtl/bg_lsu_switch_ctrl.sv
// Context sequencer for the 4x4 BG<->LSU crossbar switch port.
// A table of up to DEPTH 8-bit switch contexts is loaded over a valid/ready
// port, then replayed (one context per step_en) for max(iter_num,1) iterations.
// Optional feature macro: BG_LSU_CONFLICT_CHK_EN -- when defined, flags BG
// fields that select the same LSU; when undefined conflict outputs are tied 0.
module bg_lsu_switch_ctrl #(
    parameter int DEPTH = 8,
    parameter int IW    = 16
) (
    input logic                clk,
    input logic                rst,
    bg_lsu_switch_ctrl_if.slave io_bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_ctx_cnt;
    logic [IW-1:0] r_iter;
    logic [IW-1:0] r_iter_max;
    logic [7:0]    r_table [DEPTH];
    logic [7:0]    r_switch;
    logic          r_switch_valid;
    logic [AW-1:0] r_ctx_idx;
    logic          r_busy;
    logic          r_done;
    // Set when a load overflowed the table: the rest of that burst is refused
    // until cfg_valid drops, so excess words cannot start a new load.
    logic          r_drop;

    logic          w_cfg_ready;
    logic          w_cfg_acc;
    logic [AW-1:0] w_wr_addr;
    logic          w_first;
    logic          w_step;
    logic          w_wrap;
    logic          w_iter_last;
    logic          w_finish;
    logic [AW-1:0] w_next_idx;
    logic [AW-1:0] w_load_idx;
    logic          w_sw_load;
    logic [7:0]    w_sw_next;

    assign w_cfg_ready = ((r_state == ST_IDLE) && !r_drop) || (r_state == ST_LOAD);
    assign w_cfg_acc   = io_bus.cfg_valid && w_cfg_ready;
    // A word accepted in IDLE always opens a fresh load at entry 0.
    assign w_wr_addr   = (r_state == ST_IDLE) ? '0 : r_wr_ptr[AW-1:0];

    // First RUN cycle only presents context 0; steps count once a context is live.
    assign w_first     = (r_state == ST_RUN) && !r_switch_valid;
    assign w_step      = (r_state == ST_RUN) && r_switch_valid && io_bus.step_en;
    assign w_wrap      = ({1'b0, r_ctx_idx} == (r_ctx_cnt - 1'b1));
    assign w_iter_last = (r_iter == (r_iter_max - 1'b1));
    assign w_finish    = w_step && w_wrap && w_iter_last;
    assign w_next_idx  = w_wrap ? '0 : (r_ctx_idx + 1'b1);
    assign w_load_idx  = w_first ? r_ctx_idx : w_next_idx;
    assign w_sw_load   = w_first || (w_step && !w_finish);
    assign w_sw_next   = r_table[w_load_idx];

    // Context table: cleared on reset, written by accepted config words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_cfg_acc) begin
            r_table[w_wr_addr] <= io_bus.cfg_data;
        end
    end

    // Sequencer FSM with registered switch/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr_ptr       <= '0;
            r_ctx_cnt      <= '0;
            r_iter         <= '0;
            r_iter_max     <= '0;
            r_switch       <= '0;
            r_switch_valid <= 1'b0;
            r_ctx_idx      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_drop         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == ST_IDLE) && !io_bus.cfg_valid) begin
                r_drop <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_acc) begin
                        r_wr_ptr <= (AW+1)'(1);
                        if (io_bus.cfg_last) begin
                            r_ctx_cnt <= (AW+1)'(1);
                        end else begin
                            r_ctx_cnt <= '0;
                            r_state   <= ST_LOAD;
                            r_busy    <= 1'b1;
                        end
                    end else if (io_bus.start && (r_ctx_cnt != '0)) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_ctx_idx  <= '0;
                        r_iter     <= '0;
                        r_iter_max <= (io_bus.iter_num == '0) ? IW'(1) : io_bus.iter_num;
                    end
                end
                ST_LOAD: begin
                    if (w_cfg_acc) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (io_bus.cfg_last) begin
                            r_ctx_cnt <= r_wr_ptr + 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end else if (r_wr_ptr == (AW+1)'(DEPTH - 1)) begin
                            r_ctx_cnt <= (AW+1)'(DEPTH);
                            r_drop    <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_finish) begin
                        r_state        <= ST_DONE;
                        r_switch_valid <= 1'b0;
                        r_done         <= 1'b1;
                    end else if (w_step && w_wrap) begin
                        r_iter <= r_iter + 1'b1;
                    end
                    if (w_sw_load) begin
                        r_switch       <= w_sw_next;
                        r_switch_valid <= 1'b1;
                        r_ctx_idx      <= w_load_idx;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.cfg_ready    = w_cfg_ready;
    assign io_bus.switch       = r_switch;
    assign io_bus.switch_valid = r_switch_valid;
    assign io_bus.ctx_idx      = r_ctx_idx;
    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;

`ifdef BG_LSU_CONFLICT_CHK_EN
    // Bit i set when BG field i selects the same LSU as any other BG field.
    function automatic logic [3:0] f_conflict(input logic [7:0] sw);
        logic [3:0] m;
        m = '0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                if ((a != b) && (sw[2*a +: 2] == sw[2*b +: 2])) begin
                    m[a] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    logic [3:0] r_conf_mask;
    logic       r_conflict;
    logic [3:0] w_conf_next;

    assign w_conf_next = f_conflict(w_sw_next);

    // Conflict flags follow the switch register; conflict clears with switch_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conf_mask <= '0;
            r_conflict  <= 1'b0;
        end else if (w_sw_load) begin
            r_conf_mask <= w_conf_next;
            r_conflict  <= |w_conf_next;
        end else if (w_finish) begin
            r_conflict  <= 1'b0;
        end
    end

    assign io_bus.conflict      = r_conflict;
    assign io_bus.conflict_mask = r_conf_mask;
`else
    assign io_bus.conflict      = 1'b0;
    assign io_bus.conflict_mask = 4'h0;
`endif
endmodule

// File: tb/tb_bg_lsu_switch_ctrl.sv
// Self-checking bench for bg_lsu_switch_ctrl: directed and randomized loads and
// replays, compared against a table/queue reference model.
module tb_bg_lsu_switch_ctrl;
    localparam int DEPTH = 8;
    localparam int IW    = 16;
`ifdef BG_LSU_CONFLICT_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bg_lsu_switch_ctrl_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

    bg_lsu_switch_ctrl #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_tab [DEPTH];
    int         m_cnt = 0;
    logic [7:0] ld_buf [16];

    // Reference conflict mask: field i flagged if it equals any other field.
    function automatic logic [3:0] ref_mask(input logic [7:0] ctx);
        int         f [4];
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) f[i] = int'((ctx >> (2*i)) & 8'h03);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && f[i] == f[j]) m[i] = 1'b1;
        return CHK_EN ? m : 4'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push ld_buf[0..n-1] through the config port; model takes the table.
    task automatic load(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 100) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = ld_buf[k];
            bus.cfg_last  = (k == n - 1);
            if (bus.cfg_ready) k++;
            tick();
            guard++;
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        chk("load_words_accepted", 32'(k), 32'(n));
        for (int i = 0; i < n; i++) m_tab[i] = ld_buf[i];
        m_cnt = n;
        $display("load: %0d words, ctx_cnt=%0d", n, m_cnt);
    endtask

    // Start a replay and follow it to done. mode 0: step every cycle,
    // 1: step toggling 1,0,1,0, 2: random step_en.
    task automatic do_run(input int iters, input int mode);
        logic [7:0] exp_sw [$];
        int         exp_idx [$];
        int         eff;
        int         cyc;
        int         k;
        int         budget;
        bit         se;
        eff = (iters == 0) ? 1 : iters;
        for (int it = 0; it < eff; it++)
            for (int c = 0; c < m_cnt; c++) begin
                exp_sw.push_back(m_tab[c]);
                exp_idx.push_back(c);
            end
        budget = 4 * eff * m_cnt + 20;
        bus.iter_num = IW'(iters);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.iter_num = IW'($urandom);
        chk("run_busy_enter", 32'(bus.busy), 32'd1);
        chk("run_first_not_valid", 32'(bus.switch_valid), 32'd0);
        bus.step_en = 1'($urandom_range(0, 1));
        tick();
        cyc = 0;
        k = 0;
        while (exp_sw.size() > 0) begin
            if (cyc > budget) begin
                chk("run_timeout", 32'(exp_sw.size()), 32'd0);
                break;
            end
            chk("run_valid", 32'(bus.switch_valid), 32'd1);
            chk("run_switch", 32'(bus.switch), 32'(exp_sw[0]));
            chk("run_ctx_idx", 32'(bus.ctx_idx), 32'(exp_idx[0]));
            chk("run_mask", 32'(bus.conflict_mask), 32'(ref_mask(exp_sw[0])));
            chk("run_conflict", 32'(bus.conflict), 32'(|ref_mask(exp_sw[0])));
            chk("run_no_early_done", 32'(bus.done), 32'd0);
            case (mode)
                0:       se = 1'b1;
                1:       se = (k % 2 == 0);
                default: se = 1'($urandom_range(0, 1));
            endcase
            bus.step_en = se;
            if (se) begin
                void'(exp_sw.pop_front());
                void'(exp_idx.pop_front());
            end
            k++;
            tick();
            cyc++;
        end
        bus.step_en = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_valid_low", 32'(bus.switch_valid), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_conflict_low", 32'(bus.conflict), 32'd0);
        tick();
        chk("after_done_low", 32'(bus.done), 32'd0);
        chk("after_done_idle", 32'(bus.busy), 32'd0);
        $display("run: ctx=%0d iter_num=%0d mode=%0d cycles=%0d", m_cnt, iters, mode, cyc);
    endtask

    initial begin
        int g;
        int n;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.start     = 1'b0;
        bus.iter_num  = '0;
        bus.step_en   = 1'b0;

        // reset state
        #1;
        chk("rst_switch", 32'(bus.switch), 32'd0);
        chk("rst_valid", 32'(bus.switch_valid), 32'd0);
        chk("rst_idx", 32'(bus.ctx_idx), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_conflict", 32'(bus.conflict), 32'd0);
        chk("rst_mask", 32'(bus.conflict_mask), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("idle_ready", 32'(bus.cfg_ready), 32'd1);
        $display("reset released");

        // start with an empty table is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("empty_busy", 32'(bus.busy), 32'd0);
        chk("empty_valid", 32'(bus.switch_valid), 32'd0);
        tick();
        chk("empty_busy2", 32'(bus.busy), 32'd0);
        $display("empty-table start checked");

        // three contexts, two iterations, continuous then toggling step_en
        ld_buf[0] = 8'hE4; ld_buf[1] = 8'h1B; ld_buf[2] = 8'h4E;
        load(3);
        do_run(2, 0);
        do_run(2, 1);

        // overflow: 9 words without cfg_last
        for (int i = 0; i < 9; i++) ld_buf[i] = 8'($urandom);
        bus.cfg_valid = 1'b1;
        bus.cfg_last  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.cfg_data = ld_buf[i];
            chk("ovf_ready_word", 32'(bus.cfg_ready), 32'd1);
            tick();
        end
        bus.cfg_data = ld_buf[8];
        chk("ovf_ready_drop", 32'(bus.cfg_ready), 32'd0);
        tick();
        chk("ovf_ready_hold", 32'(bus.cfg_ready), 32'd0);
        bus.cfg_valid = 1'b0;
        tick();
        chk("ovf_ready_back", 32'(bus.cfg_ready), 32'd1);
        for (int i = 0; i < 8; i++) m_tab[i] = ld_buf[i];
        m_cnt = 8;
        $display("overflow load: 9 words offered, ctx_cnt=8");
        do_run(1, 2);

        // single context with iter_num=0, then several iterations
        ld_buf[0] = 8'h14;
        load(1);
        do_run(0, 0);
        do_run(3, 2);

        // conflict patterns
        ld_buf[0] = 8'h00; ld_buf[1] = 8'hE4; ld_buf[2] = 8'h14;
        load(3);
        do_run(1, 1);

        // randomized loads and replays
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) ld_buf[i] = 8'($urandom);
            load(n);
            do_run($urandom_range(0, 3), 2);
        end

        // asynchronous reset in the middle of a replay
        ld_buf[0] = 8'hE4; ld_buf[1] = 8'h1B; ld_buf[2] = 8'h4E;
        load(3);
        bus.iter_num = IW'(2);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.step_en  = 1'b1;
        g = 0;
        while (!(bus.switch_valid && bus.ctx_idx == 1) && g < 20) begin
            tick();
            g++;
        end
        chk("mid_reach_idx1", 32'(bus.ctx_idx), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_switch", 32'(bus.switch), 32'd0);
        chk("mid_rst_valid", 32'(bus.switch_valid), 32'd0);
        chk("mid_rst_idx", 32'(bus.ctx_idx), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        bus.step_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("post_rst_start_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("post_rst_start_valid", 32'(bus.switch_valid), 32'd0);
        $display("mid-run reset checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
